// File: rtl/s_ram_pkg.sv
// Shared types and constants for the S-RAM arbiter and its round-robin picker.
package s_ram_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;
   localparam int MAX_REQ    = 4;
   localparam int IDX_W      = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } arb_state_t;

   // Next requester index in round-robin order, wrapping at n.
   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int n);
      if (int'(idx) >= n - 1) begin
         return '0;
      end
      return idx + 1'b1;
   endfunction

endpackage

// File: rtl/s_ram_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or after start_i wins.
module rr_pick
   import s_ram_pkg::*;
#(
   parameter int N_REQ = 3
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] start_i,
   output logic [N_REQ-1:0] onehot_o,
   output logic             found_o
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      onehot_o = '0;
      found_o  = 1'b0;
      cand     = start_i;
      for (int k = 0; k < N_REQ; k++) begin
         if (!found_o && req_i[cand]) begin
            onehot_o[cand] = 1'b1;
            found_o        = 1'b1;
         end
         cand = wrap_inc(cand, N_REQ);
      end
   end

endmodule

// File: rtl/s_ram_arbiter.sv
// Round-robin owner arbiter for the single-port S-RAM, with lock support for atomic swaps.
// Handshake: a requester raises req and waits for its gnt bit; every cycle it then holds
// gnt with req high is one RAM access, reads answer with an rvalid pulse one cycle later.
module s_ram_arbiter
   import s_ram_pkg::*;
#(
   parameter int N_REQ  = 3,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ-1:0]         lock,
   input  logic [N_REQ-1:0]         we,
   input  logic [N_REQ*ADDR_W-1:0]  addr,
   input  logic [N_REQ*DATA_W-1:0]  wdata,
   output logic [N_REQ-1:0]         gnt,
   output logic [N_REQ-1:0]         rvalid,
   output logic [DATA_W-1:0]        rdata,
   output logic                     busy,
   output logic [ADDR_W-1:0]        ram_addr,
   output logic [DATA_W-1:0]        ram_data,
   output logic                     ram_wren,
   input  logic [DATA_W-1:0]        ram_q,
   output logic                     dbg_state
);

   arb_state_t       state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [N_REQ-1:0] rvalid_q, rvalid_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

   logic [ADDR_W-1:0] addr_a  [N_REQ];
   logic [DATA_W-1:0] wdata_a [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_split
      assign addr_a[g]  = addr[g*ADDR_W +: ADDR_W];
      assign wdata_a[g] = wdata[g*DATA_W +: DATA_W];
   end

   logic [IDX_W-1:0] next_idx;
   logic [IDX_W-1:0] pick_start;
   logic [N_REQ-1:0] pick_oh;
   logic             pick_found;
   logic [IDX_W-1:0] pick_idx;

   // On release the search starts just past the old owner, so it goes to the back.
   assign next_idx   = wrap_inc(owner_q, N_REQ);
   assign pick_start = (state_q == OWNED) ? next_idx : rr_ptr_q;

   rr_pick #(
      .N_REQ (N_REQ)
   ) u_rr_pick (
      .req_i    (req),
      .start_i  (pick_start),
      .onehot_o (pick_oh),
      .found_o  (pick_found)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_oh[i]) begin
            pick_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      rvalid_d = '0;
      ram_addr = '0;
      ram_data = '0;
      ram_wren = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d = OWNED;
               gnt_d   = pick_oh;
               owner_d = pick_idx;
            end
         end
         OWNED: begin
            ram_addr = addr_a[owner_q];
            ram_data = wdata_a[owner_q];
            if (req[owner_q]) begin
               ram_wren = we[owner_q];
               if (!we[owner_q]) begin
                  rvalid_d[owner_q] = 1'b1;
               end
            end else if (!lock[owner_q]) begin
               rr_ptr_d = next_idx;
               if (pick_found) begin
                  gnt_d   = pick_oh;
                  owner_d = pick_idx;
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         rvalid_q <= '0;
         owner_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         rvalid_q <= rvalid_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign gnt       = gnt_q;
   assign rvalid    = rvalid_q;
   assign rdata     = ram_q;
   assign busy      = |gnt_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_s_ram_arbiter.sv
// Bench for s_ram_arbiter: behavioural ownership model plus directed literal scenarios.
module tb_s_ram_arbiter;

   localparam int N  = 3;
   localparam int AW = 8;
   localparam int DW = 8;

   logic            clk   = 1'b0;
   logic            reset = 1'b0;
   logic [N-1:0]    req   = '0;
   logic [N-1:0]    lock  = '0;
   logic [N-1:0]    we    = '0;
   logic [N*AW-1:0] addr  = '0;
   logic [N*DW-1:0] wdata = '0;
   logic [N-1:0]    gnt;
   logic [N-1:0]    rvalid;
   logic [DW-1:0]   rdata;
   logic            busy;
   logic [AW-1:0]   ram_addr;
   logic [DW-1:0]   ram_data;
   logic            ram_wren;
   logic [DW-1:0]   ram_q;
   logic            dbg_state;

   int total = 0;
   int bad   = 0;

   s_ram_arbiter #(
      .N_REQ  (N),
      .ADDR_W (AW),
      .DATA_W (DW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .lock      (lock),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .gnt       (gnt),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .busy      (busy),
      .ram_addr  (ram_addr),
      .ram_data  (ram_data),
      .ram_wren  (ram_wren),
      .ram_q     (ram_q),
      .dbg_state (dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   // ramcore stand-in: registered address, unregistered q
   logic [7:0] ram_mem [256];
   logic [7:0] ram_addr_q = '0;
   assign ram_q = ram_mem[ram_addr_q];

   initial begin
      for (int i = 0; i < 256; i++) ram_mem[i] = 8'(i) ^ 8'h5A;
      ram_mem[8'h10] = 8'hAA;
      ram_mem[8'h20] = 8'h55;
      forever begin
         @(posedge clk);
         if (ram_wren) ram_mem[ram_addr] = ram_data;
         ram_addr_q = ram_addr;
      end
   end

   // behavioural reference: owner index, round-robin start, shadow memory
   int         m_owner = -1;
   int         m_ptr   = 0;
   int         m_rv    = -1;
   logic [7:0] m_mem [256];
   logic [DW-1:0] exp_q [$];

   function automatic logic [AW-1:0] addr_of(int i);
      return addr[i*AW +: AW];
   endfunction

   function automatic logic [DW-1:0] wdata_of(int i);
      return wdata[i*DW +: DW];
   endfunction

   function automatic int pick(logic [N-1:0] r, int start);
      for (int k = 0; k < N; k++) begin
         if (r[(start + k) % N]) return (start + k) % N;
      end
      return -1;
   endfunction

   initial begin
      for (int i = 0; i < 256; i++) m_mem[i] = 8'(i) ^ 8'h5A;
      m_mem[8'h10] = 8'hAA;
      m_mem[8'h20] = 8'h55;
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            m_owner = -1;
            m_ptr   = 0;
            m_rv    = -1;
            exp_q.delete();
         end else begin
            int nrv;
            nrv = -1;
            if (m_owner >= 0) begin
               if (req[m_owner]) begin
                  if (we[m_owner]) m_mem[addr_of(m_owner)] = wdata_of(m_owner);
                  else begin
                     nrv = m_owner;
                     exp_q.push_back(m_mem[addr_of(m_owner)]);
                  end
               end else if (!lock[m_owner]) begin
                  m_ptr   = (m_owner + 1) % N;
                  m_owner = pick(req, m_ptr);
               end
            end else begin
               m_owner = pick(req, m_ptr);
            end
            m_rv = nrv;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp_v, $time);
      end
   endtask

   task automatic compare();
      logic [N-1:0] eg, erv;
      logic         ew;
      eg  = '0;
      erv = '0;
      ew  = 1'b0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      if (m_rv >= 0) erv[m_rv] = 1'b1;
      if (m_owner >= 0 && req[m_owner]) ew = we[m_owner];
      chk("gnt", gnt, eg);
      chk("busy", busy, m_owner >= 0);
      chk("dbg_state", dbg_state, m_owner >= 0);
      chk("rvalid", rvalid, erv);
      chk("ram_wren", ram_wren, ew);
      if (m_rv >= 0 && exp_q.size() > 0) chk("rdata", rdata, exp_q.pop_front());
      if (m_owner < 0) begin
         chk("ram_addr_idle", ram_addr, 0);
         chk("ram_data_idle", ram_data, 0);
      end else if (req[m_owner]) begin
         chk("ram_addr", ram_addr, addr_of(m_owner));
         chk("ram_data", ram_data, wdata_of(m_owner));
      end
   endtask

   // per-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         compare();
      end
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req   = '0;
      lock  = '0;
      we    = '0;
      reset = 1'b0;
      step();
      reset = 1'b1;
   endtask

   task automatic row(input logic [2:0] r, input logic [2:0] l, input logic [2:0] w,
                      input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                      input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                      input logic [2:0] eg, input logic [2:0] erv, input logic [7:0] erd,
                      input logic ew);
      req   = r;
      lock  = l;
      we    = w;
      addr  = {a2, a1, a0};
      wdata = {d2, d1, d0};
      @(negedge clk);
      chk("d_gnt", gnt, eg);
      chk("d_busy", busy, |eg);
      chk("d_rvalid", rvalid, erv);
      chk("d_wren", ram_wren, ew);
      if (erv != 3'b000) chk("d_rdata", rdata, erd);
      step();
   endtask

   initial begin
      // reset state
      step();
      @(negedge clk);
      chk("rst_gnt", gnt, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_wren", ram_wren, 0);
      chk("rst_addr", ram_addr, 0);
      chk("rst_data", ram_data, 0);
      step();
      reset = 1'b1;

      // single read by requester 0
      row(3'b001, 3'b000, 3'b000, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000, 3'b000, 8'h00, 1'b0);
      row(3'b001, 3'b000, 3'b000, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'b001, 3'b000, 8'h00, 1'b0);
      row(3'b000, 3'b000, 3'b000, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'b001, 3'b001, 8'h5F, 1'b0);
      row(3'b000, 3'b000, 3'b000, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000, 3'b000, 8'h00, 1'b0);

      // rotation with all three requesting, one access each
      do_reset();
      row(3'b111, 3'b000, 3'b000, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 3'b000, 3'b000, 8'h00, 1'b0);
      row(3'b111, 3'b000, 3'b000, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 3'b001, 3'b000, 8'h00, 1'b0);
      row(3'b110, 3'b000, 3'b000, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 3'b001, 3'b001, 8'h5B, 1'b0);
      row(3'b110, 3'b000, 3'b000, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 3'b010, 3'b000, 8'h00, 1'b0);
      row(3'b101, 3'b000, 3'b000, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 3'b010, 3'b010, 8'h58, 1'b0);
      row(3'b101, 3'b000, 3'b000, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 3'b100, 3'b000, 8'h00, 1'b0);
      row(3'b011, 3'b000, 3'b000, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 3'b100, 3'b100, 8'h59, 1'b0);
      row(3'b011, 3'b000, 3'b000, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 3'b001, 3'b000, 8'h00, 1'b0);
      row(3'b000, 3'b000, 3'b000, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 3'b001, 3'b001, 8'h5B, 1'b0);
      row(3'b000, 3'b000, 3'b000, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 3'b000, 3'b000, 8'h00, 1'b0);

      // locked swap by requester 1 while requester 0 waits
      row(3'b011, 3'b010, 3'b000, 8'h10, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000, 3'b000, 8'h00, 1'b0);
      row(3'b011, 3'b010, 3'b000, 8'h10, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 3'b010, 3'b000, 8'h00, 1'b0);
      row(3'b011, 3'b010, 3'b000, 8'h10, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 3'b010, 3'b010, 8'hAA, 1'b0);
      row(3'b011, 3'b010, 3'b010, 8'h10, 8'h10, 8'h00, 8'h00, 8'h55, 8'h00, 3'b010, 3'b010, 8'h55, 1'b1);
      row(3'b011, 3'b010, 3'b010, 8'h10, 8'h20, 8'h00, 8'h00, 8'hAA, 8'h00, 3'b010, 3'b000, 8'h00, 1'b1);
      row(3'b001, 3'b010, 3'b000, 8'h10, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 3'b010, 3'b000, 8'h00, 1'b0);
      row(3'b001, 3'b000, 3'b000, 8'h10, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 3'b010, 3'b000, 8'h00, 1'b0);
      row(3'b001, 3'b000, 3'b000, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'b001, 3'b000, 8'h00, 1'b0);
      row(3'b001, 3'b000, 3'b000, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'b001, 3'b001, 8'h55, 1'b0);
      row(3'b000, 3'b000, 3'b000, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'b001, 3'b001, 8'hAA, 1'b0);
      row(3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000, 3'b000, 8'h00, 1'b0);

      // write 0x7F, read back, then hand over to waiting requester 2
      do_reset();
      row(3'b001, 3'b000, 3'b001, 8'h7F, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00, 3'b000, 3'b000, 8'h00, 1'b0);
      row(3'b001, 3'b000, 3'b001, 8'h7F, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00, 3'b001, 3'b000, 8'h00, 1'b1);
      row(3'b101, 3'b000, 3'b000, 8'h7F, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00, 3'b001, 3'b000, 8'h00, 1'b0);
      row(3'b100, 3'b000, 3'b000, 8'h7F, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00, 3'b001, 3'b001, 8'h3C, 1'b0);
      row(3'b100, 3'b000, 3'b000, 8'h7F, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00, 3'b100, 3'b000, 8'h00, 1'b0);
      row(3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'b100, 3'b100, 8'h3C, 1'b0);
      row(3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000, 3'b000, 8'h00, 1'b0);

      // asynchronous reset while requester 1 owns with a read pending
      row(3'b010, 3'b000, 3'b000, 8'h00, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000, 3'b000, 8'h00, 1'b0);
      row(3'b010, 3'b000, 3'b000, 8'h00, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 3'b010, 3'b000, 8'h00, 1'b0);
      req   = 3'b010;
      we    = 3'b010;
      addr  = {8'h00, 8'h33, 8'h00};
      wdata = {8'h00, 8'h99, 8'h00};
      @(negedge clk);
      chk("ar_gnt_before", gnt, 3'b010);
      chk("ar_rvalid_before", rvalid, 3'b010);
      chk("ar_rdata_before", rdata, 8'h1E);
      #2;
      reset = 1'b0;
      #1;
      chk("ar_gnt", gnt, 0);
      chk("ar_rvalid", rvalid, 0);
      chk("ar_wren", ram_wren, 0);
      chk("ar_busy", busy, 0);
      step();
      reset = 1'b1;
      we    = 3'b000;
      row(3'b010, 3'b000, 3'b000, 8'h00, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000, 3'b000, 8'h00, 1'b0);
      row(3'b010, 3'b000, 3'b000, 8'h00, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 3'b010, 3'b000, 8'h00, 1'b0);
      row(3'b000, 3'b000, 3'b000, 8'h00, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 3'b010, 3'b010, 8'h69, 1'b0);

      // randomized traffic, checked every cycle by the model
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            req[i]  = ($urandom_range(0, 9) < 6);
            lock[i] = ($urandom_range(0, 3) == 0);
            we[i]   = ($urandom_range(0, 9) < 3);
            addr[i*AW +: AW]  = 8'($urandom_range(0, 15));
            wdata[i*DW +: DW] = 8'($urandom);
         end
         step();
      end

      req  = '0;
      lock = '0;
      we   = '0;
      repeat (4) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/s_ram_arbiter.md
# s_ram_arbiter

Arbitrates the single-port 256×8 S-RAM (`ramcore`) between up to `N_REQ` requesters, such as KSA init/swap, PRGA and the decrypt checker. It grants exclusive ownership round-robin and supports a lock for atomic read-modify-write swaps. It also muxes address, data and write enable to the RAM and returns per-requester read-valid strobes aligned to the RAM's one-cycle read latency. It sits between the `arcfour`-level sequencers and the RAM instance.

## Interface
Parameters:
- `N_REQ`, 3: number of requesters (2..4).
- `ADDR_W`, 8: RAM address width.
- `DATA_W`, 8: RAM data width.

Ports:
- `clk`  in  1: single clock, all state on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `req`  in  `N_REQ`: per-requester access request. A request is an access when granted.
- `lock`  in  `N_REQ`: holds the grant while high, even with `req` low.
- `we`  in  `N_REQ`: 1 = write, 0 = read, for the access in the current cycle.
- `addr`  in  `N_REQ*ADDR_W`: requester i uses bits `[i*ADDR_W +: ADDR_W]`.
- `wdata`  in  `N_REQ*DATA_W`: requester i uses bits `[i*DATA_W +: DATA_W]`.
- `gnt`  out  `N_REQ`: registered, one-hot or zero. Identifies the current owner.
- `rvalid`  out  `N_REQ`: registered one-cycle pulse. `rdata` is valid for that requester.
- `rdata`  out  `DATA_W`: equal to `ram_q`, shared by all requesters.
- `busy`  out  1: high when any `gnt` bit is set.
- `ram_addr`  out  `ADDR_W`, `ram_data`  out  `DATA_W`, `ram_wren`  out  1: drive the RAM ports.
- `ram_q`  in  `DATA_W`: RAM read data, registered address with unregistered q.

## Operation
- States: IDLE (no owner) and OWNED(i).
- IDLE:
  - If any `req` is high, pick the winner round-robin starting at `rr_ptr`.
  - Set `gnt` to the winner on the next edge, then go to OWNED.
- OWNED(i), access cycle (`req[i]` high):
  - Drive `ram_addr`=`addr[i]`, `ram_data`=`wdata[i]`, `ram_wren`=`we[i]` combinationally.
  - If `we[i]`=0, set `rvalid[i]`=1 on the next edge.
- OWNED(i), idle cycle (`req[i]` low, `lock[i]` high):
  - Keep the grant. `ram_wren`=0, and no `rvalid` follows.
- OWNED(i), release (`req[i]` low and `lock[i]` low at an edge):
  - Set `rr_ptr` to i+1 mod `N_REQ`.
  - If other requests are pending, regrant round-robin from i+1 on the same edge.
  - Otherwise go to IDLE with `gnt`=0.
- Requests from non-owners are ignored. They wait, and no request is lost while held.
- No owner: `ram_addr`=0, `ram_data`=0, `ram_wren`=0.
- `rvalid` is never asserted for a write cycle or for a non-owner.
- A requester that has released and immediately re-requests goes to the back of the round-robin order.

## Timing
- Reset values: `gnt`=0, `rvalid`=0, `busy`=0, `ram_wren`=0, `ram_addr`=0, `ram_data`=0, `rr_ptr`=0, state IDLE.
- Grant latency:
  - `req` rises at cycle t from IDLE: `gnt` is high at t+1.
  - The first access is at t+1 if `req` is still high.
- Read latency: an access at cycle t gives `rvalid`/`rdata` at t+1.
- Back-to-back accesses every cycle are allowed while the grant is held.
- Swap (read i, read j, write i, write j) under `lock`: no other requester can touch the RAM between the steps.
- Handover:
  - The owner's release cycle t is dead (no access).
  - The new owner's `gnt` is high at t+1.
  - A read issued in the owner's last access cycle still gets its `rvalid` after `gnt` has moved.
- Simultaneous release and new requests: the round-robin pick from i+1 applies. Requests arriving in the same cycle as the release are eligible.
- Asynchronous reset mid-operation clears the grant and any pending `rvalid` immediately. An in-flight RAM write from that cycle is not guaranteed.

## Structure
- `s_ram_pkg`: `ADDR_W`/`DATA_W` defaults, the `arb_state_t` enum {IDLE, OWNED}, and the `N_REQ` limit.
- Sub-module `rr_pick`: combinational round-robin priority encoder. Inputs are the request vector and the start pointer. Outputs are a one-hot winner and a found flag.
- The arbiter holds the state register, `gnt`, `rr_ptr`, a registered read-pending/owner index, and the output mux.

## Test plan
- Reset, then `req`=001: `gnt`=001 one cycle later. A read of addr 0x05 returns `rvalid[0]` plus the stored value the next cycle. `busy`=1.
- `req`=111 held with each requester releasing after one access: grants follow 001→010→100→001, with one dead cycle per handover.
- Requester 1 locks and swaps S[0x10]=0xAA with S[0x20]=0x55 while requester 0 holds `req` high throughout: `gnt[0]` stays low until `lock[1]` and `req[1]` fall. Final reads give S[0x10]=0x55 and S[0x20]=0xAA.
- Owner write with `we`=1, addr 0x7F, data 0x3C: `ram_wren`=1 for exactly that cycle and no `rvalid`. A later read of 0x7F returns 0x3C.
- Owner does a read in cycle t and releases at t+1 with requester 2 pending: `rvalid[0]` at t+1, `gnt`=100 at t+2.
- `reset` asserted low while `gnt`=010 and a read is pending: `gnt`, `rvalid` and `ram_wren` go to 0 immediately. After release, a `req`=010 request is granted per `rr_ptr`=0.
